// File: rtl/multiplier_controller_taint_track_1bit.sv
// Moore FSM that sequences a shift-add multiplier datapath, testing multiplier bits LSB-first.
// A single sticky taint bit follows the control decisions and is copied onto every control output.
module multiplier_controller_taint_track_1bit #(
  parameter int WIDTH = 4,
  localparam int IDXW = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             start_t,
  input  logic [WIDTH-1:0] multiplierReg,
  input  logic             multiplierReg_t,
  output logic             rsclear,
  output logic             rsclear_t,
  output logic             rsload,
  output logic             rsload_t,
  output logic             rsshr,
  output logic             rsshr_t,
  output logic             mrld,
  output logic             mrld_t,
  output logic             mdld,
  output logic             mdld_t,
  output logic             busy,
  output logic             busy_t,
  output logic             done,
  output logic             done_t,
  output logic [IDXW-1:0]  bit_idx
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] TEST  = 3'd2;
  localparam logic [2:0] ADD   = 3'd3;
  localparam logic [2:0] SHIFT = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

  logic [2:0]       state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             taint_q, taint_d;
  logic [WIDTH-1:0] shiftedMr;
  logic             testBit;

  // Shifting instead of indexing keeps the bit select legal for any WIDTH.
  assign shiftedMr = multiplierReg >> idx_q;
  assign testBit   = shiftedMr[0];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    taint_d = taint_q;
    case (state_q)
      IDLE: begin
        taint_d = start_t;
        if (start) state_d = LOAD;
      end
      LOAD: begin
        idx_d   = '0;
        state_d = TEST;
      end
      TEST: begin
        taint_d = taint_q | multiplierReg_t;
        state_d = testBit ? ADD : SHIFT;
      end
      ADD:   state_d = SHIFT;
      SHIFT: begin
        idx_d   = idx_q + IDXW'(1);
        state_d = (idx_q == LAST_IDX) ? DONE : TEST;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      taint_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      taint_q <= taint_d;
    end
  end

  assign rsclear = (state_q == LOAD);
  assign mrld    = (state_q == LOAD);
  assign mdld    = (state_q == LOAD);
  assign rsload  = (state_q == ADD);
  assign rsshr   = (state_q == SHIFT);
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign bit_idx = idx_q;

  // Taint applies to every output regardless of whether the paired control is asserted.
  assign rsclear_t = taint_q;
  assign rsload_t  = taint_q;
  assign rsshr_t   = taint_q;
  assign mrld_t    = taint_q;
  assign mdld_t    = taint_q;
  assign busy_t    = taint_q;
  assign done_t    = taint_q;

endmodule
